traffic_phase_fsm: RTL and testbench

Phase sequencer for the traffic light controller. Holds the current signal phase, advances it on the companion timer's `time_out` pulse, and drives `c_state` back to that timer so it can reload the next phase duration. Also decodes the registered lamp outputs for main and side roads, and handles the side-road vehicle sensor, pedestrian request/acknowledge and emergency pre-emption.

---
 rtl/traffic_phase_fsm_pkg.sv | 36 +++
 rtl/traffic_phase_fsm_ped_req_latch.sv | 29 ++
 rtl/traffic_phase_fsm.sv | 93 +++++++++
 tb/tb_traffic_phase_fsm.sv | 132 +++++++++++++
 4 files changed

// File: rtl/traffic_phase_fsm_pkg.sv
// Shared phase encodings and lamp constants for the traffic light controller.
// The companion timer decodes the same phase encodings to pick its reload value.
package traffic_phase_fsm_pkg;

    typedef enum logic [1:0] {
        MG = 2'b00,
        MY = 2'b10,
        SG = 2'b11,
        SY = 2'b01
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [2:0] main_lamp(input phase_t p);
        case (p)
            MG:      return LAMP_G;
            MY:      return LAMP_Y;
            SG:      return LAMP_R;
            SY:      return LAMP_R;
            default: return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input phase_t p);
        case (p)
            MG:      return LAMP_R;
            MY:      return LAMP_R;
            SG:      return LAMP_G;
            SY:      return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_fsm_ped_req_latch.sv
// Pedestrian request register: any request sets it, serving clears it and
// produces a one-cycle acknowledge. A request on the serving edge stays latched.
module ped_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    input  logic serve,
    output logic pending,
    output logic ped_ack
);

    logic pending_r;
    logic ack_r;

    // Set/clear request state and acknowledge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            ack_r     <= serve & pending_r;
            pending_r <= ped_req | (pending_r & ~serve);
        end
    end

    assign pending = pending_r;
    assign ped_ack = ack_r;

endmodule

// File: rtl/traffic_phase_fsm.sv
// Phase sequencer MG -> MY -> SG -> SY -> MG with registered lamp, walk and
// acknowledge outputs decoded from the next phase.
module traffic_phase_fsm
    import traffic_phase_fsm_pkg::*;
#(
    parameter logic SENSOR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_out,
    input  logic       side_car,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [1:0] c_state,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_ack
);

    phase_t     phase_r;
    phase_t     next_phase_s;
    logic [2:0] main_light_r;
    logic [2:0] side_light_r;
    logic       walk_r;
    logic       pending_s;
    logic       serve_s;

    ped_req_latch u_ped_req_latch (
        .clk     (clk),
        .rst     (rst),
        .ped_req (ped_req),
        .serve   (serve_s),
        .pending (pending_s),
        .ped_ack (ped_ack)
    );

    // Next-phase selection; emergency pins MG and cuts SG short
    always_comb begin
        next_phase_s = phase_r;
        case (phase_r)
            MG: begin
                if (time_out && !emergency && (!SENSOR_EN || side_car || pending_s)) begin
                    next_phase_s = MY;
                end else begin
                    next_phase_s = MG;
                end
            end
            MY: begin
                if (time_out) next_phase_s = SG;
                else          next_phase_s = MY;
            end
            SG: begin
                if (time_out || emergency) next_phase_s = SY;
                else                       next_phase_s = SG;
            end
            SY: begin
                if (time_out) next_phase_s = MG;
                else          next_phase_s = SY;
            end
            default: next_phase_s = MG;
        endcase
    end

    assign serve_s = (phase_r == MY) && time_out && pending_s;

    // Phase register with outputs decoded from the next phase
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r      <= MG;
            main_light_r <= LAMP_G;
            side_light_r <= LAMP_R;
            walk_r       <= 1'b0;
        end else begin
            phase_r      <= next_phase_s;
            main_light_r <= main_lamp(next_phase_s);
            side_light_r <= side_lamp(next_phase_s);
            if (serve_s) begin
                walk_r <= 1'b1;
            end else if (phase_r == SG && next_phase_s == SY) begin
                walk_r <= 1'b0;
            end else begin
                walk_r <= walk_r;
            end
        end
    end

    assign c_state    = phase_r;
    assign main_light = main_light_r;
    assign side_light = side_light_r;
    assign walk       = walk_r;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: two instances (sensor on / fixed cycle) driven
// with the same directed and random stimulus, checked against a phase-index model.
module tb_traffic_phase_fsm;

    logic clk = 1'b0;
    logic rst, time_out, side_car, ped_req, emergency;
    logic [1:0] c_state_s    [2];
    logic [2:0] main_light_s [2];
    logic [2:0] side_light_s [2];
    logic       walk_s       [2];
    logic       ped_ack_s    [2];

    int err_cnt = 0;
    int chk_cnt = 0;

    // Model: phase as position 0..3 in the cycle MG, MY, SG, SY
    int   m_idx  [2];
    logic m_walk [2];
    logic m_ack  [2];
    logic m_pend [2];
    const logic [1:0] codes     [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    const logic [2:0] main_tab  [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    const logic [2:0] side_tab  [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
    const logic       sensor_of [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    traffic_phase_fsm #(.SENSOR_EN(1'b1)) dut_sensor (
        .clk(clk), .rst(rst), .time_out(time_out), .side_car(side_car),
        .ped_req(ped_req), .emergency(emergency),
        .c_state(c_state_s[0]), .main_light(main_light_s[0]),
        .side_light(side_light_s[0]), .walk(walk_s[0]), .ped_ack(ped_ack_s[0])
    );

    traffic_phase_fsm #(.SENSOR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst(rst), .time_out(time_out), .side_car(side_car),
        .ped_req(ped_req), .emergency(emergency),
        .c_state(c_state_s[1]), .main_light(main_light_s[1]),
        .side_light(side_light_s[1]), .walk(walk_s[1]), .ped_ack(ped_ack_s[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input int k, input logic r, t, sc, pr, em);
        int   adv;
        logic served;
        if (r) begin
            m_idx[k] = 0; m_walk[k] = 1'b0; m_ack[k] = 1'b0; m_pend[k] = 1'b0;
        end else begin
            case (m_idx[k])
                0:       adv = (t && !em && (!sensor_of[k] || sc || m_pend[k])) ? 1 : 0;
                2:       adv = (t || em) ? 1 : 0;
                default: adv = t ? 1 : 0;
            endcase
            served   = (m_idx[k] == 1) && (adv == 1) && m_pend[k];
            m_ack[k] = served;
            if (served) m_walk[k] = 1'b1;
            if (m_idx[k] == 2 && adv == 1) m_walk[k] = 1'b0;
            m_pend[k] = pr || (m_pend[k] && !served);
            m_idx[k]  = (m_idx[k] + adv) % 4;
        end
    endtask

    task automatic step(input logic r, t, sc, pr, em);
        rst = r; time_out = t; side_car = sc; ped_req = pr; emergency = em;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, r, t, sc, pr, em);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("c_state%0d", k),    {30'd0, c_state_s[k]},    {30'd0, codes[m_idx[k]]});
            check_val($sformatf("main_light%0d", k), {29'd0, main_light_s[k]}, {29'd0, main_tab[m_idx[k]]});
            check_val($sformatf("side_light%0d", k), {29'd0, side_light_s[k]}, {29'd0, side_tab[m_idx[k]]});
            check_val($sformatf("walk%0d", k),       {31'd0, walk_s[k]},       {31'd0, m_walk[k]});
            check_val($sformatf("ped_ack%0d", k),    {31'd0, ped_ack_s[k]},    {31'd0, m_ack[k]});
        end
    endtask

    initial begin
        rst = 1'b1; time_out = 1'b0; side_car = 1'b0; ped_req = 1'b0; emergency = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_walk[k] = 1'b0; m_ack[k] = 1'b0; m_pend[k] = 1'b0;
        end
        #2;
        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_c_state", {30'd0, c_state_s[0]}, 32'd0);
        check_val("reset_main", {29'd0, main_light_s[0]}, 32'd1);
        check_val("reset_side", {29'd0, side_light_s[0]}, 32'd4);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Full cycle with side demand
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // No demand: sensor instance rests in MG
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rest_in_mg", {30'd0, c_state_s[0]}, 32'd0);
        // Pedestrian served on MY->SG
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("walk_in_sg", {31'd0, walk_s[0]}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Emergency cuts SG, then pins MG
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("emerg_to_sy", {30'd0, c_state_s[0]}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        // Reset in SG with a pending request discards it
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("no_walk_after_rst", {31'd0, walk_s[0]}, 32'd0);
        // Request during SG serves the following SG
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));
        end
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
